// File: rtl/imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into words and writes the instruction BRAM.
// Optional trailing XOR checksum word is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
   parameter int          MAX_WORDS  = 1024,
   parameter int          CNT_WIDTH  = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  load_req,
   output logic [31:0]           i_w_addr,
   output logic [DATA_WIDTH-1:0] i_w_dat,
   output logic                  i_w_enb,
   output logic                  pc_stall,
   output logic                  done,
   output logic                  error,
   output logic [CNT_WIDTH-1:0]  words_loaded
);

   typedef enum logic [2:0] {
      ST_LEN,
      ST_CHECK,
      ST_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM,
`endif
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [CNT_WIDTH-1:0]  word_idx_q, word_idx_d;
   logic [31:0]           len_q, len_d;
   logic [23:0]           asm_q, asm_d;
   logic [31:0]           i_w_addr_q, i_w_addr_d;
   logic [DATA_WIDTH-1:0] i_w_dat_q, i_w_dat_d;
   logic                  i_w_enb_q, i_w_enb_d;
   logic                  pc_stall_q, pc_stall_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  rx_ready_q, rx_ready_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]           csum_q, csum_d;
`endif

   logic        accept;
   logic        last_byte;
   logic [31:0] assembled;

   assign accept    = rx_valid && rx_ready_q;
   assign last_byte = accept && (byte_idx_q == 2'd3);
   assign assembled = {rx_data, asm_q};

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      len_d      = len_q;
      asm_d      = asm_q;
      i_w_addr_d = i_w_addr_q;
      i_w_dat_d  = i_w_dat_q;
      i_w_enb_d  = 1'b0;
      pc_stall_d = pc_stall_q;
      done_d     = done_q;
      error_d    = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif

      if (accept) begin
         byte_idx_d = byte_idx_q + 2'd1;
         case (byte_idx_q)
            2'd0:    asm_d[7:0]   = rx_data;
            2'd1:    asm_d[15:8]  = rx_data;
            2'd2:    asm_d[23:16] = rx_data;
            default: asm_d        = asm_q;
         endcase
      end

      case (state_q)
         ST_LEN: begin
            if (last_byte) begin
               len_d   = assembled;
               state_d = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if ((len_q == 32'd0) || (len_q > 32'(MAX_WORDS))) begin
               state_d = ST_ERROR;
               error_d = 1'b1;
            end else begin
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (last_byte) begin
               i_w_dat_d  = assembled;
               i_w_addr_d = ADDR_BASE + (32'(word_idx_q) << 2);
               i_w_enb_d  = 1'b1;
               word_idx_d = word_idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = csum_q ^ assembled;
`endif
               if (32'(word_idx_q) + 32'd1 == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_DONE;
`endif
               end
            end
         end

`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (last_byte) begin
               if (assembled == csum_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
               end
            end
         end
`endif

         // DONE is entered with the final write still in flight, so the core is released one cycle later.
         ST_DONE: begin
            done_d     = 1'b1;
            pc_stall_d = 1'b0;
         end

         ST_ERROR: begin
            error_d    = 1'b1;
            pc_stall_d = 1'b1;
         end

         default: begin
            state_d = ST_LEN;
         end
      endcase

      if (load_req && ((state_q == ST_DONE) || (state_q == ST_ERROR))) begin
         state_d    = ST_LEN;
         byte_idx_d = 2'd0;
         word_idx_d = '0;
         i_w_addr_d = ADDR_BASE;
         pc_stall_d = 1'b1;
         done_d     = 1'b0;
         error_d    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_d     = 32'd0;
`endif
      end

      rx_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                   || (state_d == ST_CSUM)
`endif
                   ;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_LEN;
         byte_idx_q <= 2'd0;
         word_idx_q <= '0;
         len_q      <= 32'd0;
         asm_q      <= 24'd0;
         i_w_addr_q <= ADDR_BASE;
         i_w_dat_q  <= '0;
         i_w_enb_q  <= 1'b0;
         pc_stall_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         rx_ready_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= 32'd0;
`endif
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         len_q      <= len_d;
         asm_q      <= asm_d;
         i_w_addr_q <= i_w_addr_d;
         i_w_dat_q  <= i_w_dat_d;
         i_w_enb_q  <= i_w_enb_d;
         pc_stall_q <= pc_stall_d;
         done_q     <= done_d;
         error_q    <= error_d;
         rx_ready_q <= rx_ready_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign rx_ready     = rx_ready_q;
   assign i_w_addr     = i_w_addr_q;
   assign i_w_dat      = i_w_dat_q;
   assign i_w_enb      = i_w_enb_q;
   assign pc_stall     = pc_stall_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = word_idx_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader; sends byte images and checks BRAM writes and release timing.
module tb_imem_loader;

   logic        clk;
   logic        rst;
   logic [7:0]  rxData;
   logic        rxValid;
   logic        rxReady;
   logic        loadReq;
   logic [31:0] iWAddr;
   logic [31:0] iWDat;
   logic        iWEnb;
   logic        pcStall;
   logic        done;
   logic        error;
   logic [10:0] wordsLoaded;

   int testsRun  = 0;
   int failCount = 0;
   bit randomGaps = 0;

   logic [31:0] wrAddr[$];
   logic [31:0] wrDat[$];
   int negCycle       = 0;
   int lastPulseCycle = 0;
   int doneRiseCycle  = 0;
   logic prevDone     = 0;

   imem_loader #(
      .DATA_WIDTH(32),
      .ADDR_BASE (32'h0000_0000),
      .MAX_WORDS (1024),
      .CNT_WIDTH (11)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rxData),
      .rx_valid    (rxValid),
      .rx_ready    (rxReady),
      .load_req    (loadReq),
      .i_w_addr    (iWAddr),
      .i_w_dat     (iWDat),
      .i_w_enb     (iWEnb),
      .pc_stall    (pcStall),
      .done        (done),
      .error       (error),
      .words_loaded(wordsLoaded)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Record every write strobe and the cycle done first rises, sampled mid-cycle
   always @(negedge clk) begin
      negCycle++;
      if (iWEnb) begin
         wrAddr.push_back(iWAddr);
         wrDat.push_back(iWDat);
         lastPulseCycle = negCycle;
      end
      if (done && !prevDone) doneRiseCycle = negCycle;
      prevDone = done;
   end

   // Single comparison point: counts and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Offer one byte and hold it until the loader takes it
   task automatic applyStimulus(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      if (randomGaps) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      rxData  = b;
      rxValid = 1;
      while (!rxReady && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput("rx_ready timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 rxValid = 0;
   endtask

   task automatic sendWord(input logic [31:0] w);
      applyStimulus(w[7:0]);
      applyStimulus(w[15:8]);
      applyStimulus(w[23:16]);
      applyStimulus(w[31:24]);
   endtask

   // Wait (bounded) for done (which=0) or error (which=1)
   task automatic waitFlag(input int which, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (n < 200 && !((which == 0) ? done : error)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput(tag, 32'd0, 32'd1);
      @(negedge clk);
      #1;
   endtask

   task automatic pulseLoadReq(input string tag);
      @(negedge clk);
      loadReq = 1;
      @(negedge clk);
      loadReq = 0;
      #1;
      checkOutput({tag, " done"},     {31'd0, done},    32'd0);
      checkOutput({tag, " error"},    {31'd0, error},   32'd0);
      checkOutput({tag, " pc_stall"}, {31'd0, pcStall}, 32'd1);
      checkOutput({tag, " rx_ready"}, {31'd0, rxReady}, 32'd1);
      checkOutput({tag, " words"},    {21'd0, wordsLoaded}, 32'd0);
   endtask

   initial begin
      int base;
      rst = 0;
      rxData = 8'h00;
      rxValid = 0;
      loadReq = 0;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset rx_ready", {31'd0, rxReady}, 32'd0);
      checkOutput("reset pc_stall", {31'd0, pcStall}, 32'd1);
      checkOutput("reset done",     {31'd0, done},    32'd0);
      checkOutput("reset error",    {31'd0, error},   32'd0);
      checkOutput("reset i_w_enb",  {31'd0, iWEnb},   32'd0);
      checkOutput("reset i_w_addr", iWAddr,           32'h0);
      checkOutput("reset i_w_dat",  iWDat,            32'h0);
      checkOutput("reset words",    {21'd0, wordsLoaded}, 32'd0);
      rst = 1;

      // Two-word image
      base = wrAddr.size();
      sendWord(32'h0000_0002);
      sendWord(32'h0050_0013);
      sendWord(32'h0010_0093);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendWord(32'h0040_0080);
`endif
      waitFlag(0, "two-word done timeout");
      checkOutput("two-word writes", wrAddr.size() - base, 32'd2);
      if (wrAddr.size() >= base + 2) begin
         checkOutput("two-word addr0", wrAddr[base],     32'h0);
         checkOutput("two-word dat0",  wrDat[base],      32'h0050_0013);
         checkOutput("two-word addr1", wrAddr[base + 1], 32'h4);
         checkOutput("two-word dat1",  wrDat[base + 1],  32'h0010_0093);
      end
`ifndef IMEM_LOADER_CHECKSUM_EN
      checkOutput("release delay", doneRiseCycle - lastPulseCycle, 32'd1);
`endif
      checkOutput("two-word pc_stall", {31'd0, pcStall}, 32'd0);
      checkOutput("two-word words",    {21'd0, wordsLoaded}, 32'd2);
      checkOutput("two-word rx_ready", {31'd0, rxReady}, 32'd0);
      pulseLoadReq("reload from done");

      // Zero length aborts
      base = wrAddr.size();
      sendWord(32'h0000_0000);
      waitFlag(1, "len0 error timeout");
      checkOutput("len0 error",    {31'd0, error},   32'd1);
      checkOutput("len0 pc_stall", {31'd0, pcStall}, 32'd1);
      checkOutput("len0 rx_ready", {31'd0, rxReady}, 32'd0);
      checkOutput("len0 writes",   wrAddr.size() - base, 32'd0);
      pulseLoadReq("recover len0");

      // One past the maximum length aborts the same way
      base = wrAddr.size();
      sendWord(32'h0000_0401);
      waitFlag(1, "len1025 error timeout");
      checkOutput("len1025 error",    {31'd0, error},   32'd1);
      checkOutput("len1025 pc_stall", {31'd0, pcStall}, 32'd1);
      checkOutput("len1025 rx_ready", {31'd0, rxReady}, 32'd0);
      checkOutput("len1025 writes",   wrAddr.size() - base, 32'd0);
      pulseLoadReq("recover len1025");

      // Irregular rx_valid gaps
      randomGaps = 1;
      base = wrAddr.size();
      sendWord(32'h0000_0001);
      sendWord(32'hDEAD_BEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendWord(32'hDEAD_BEEF);
`endif
      randomGaps = 0;
      waitFlag(0, "gappy done timeout");
      checkOutput("gappy writes", wrAddr.size() - base, 32'd1);
      if (wrAddr.size() >= base + 1) begin
         checkOutput("gappy dat",  wrDat[base],  32'hDEAD_BEEF);
         checkOutput("gappy addr", wrAddr[base], 32'h0);
      end
      checkOutput("gappy words", {21'd0, wordsLoaded}, 32'd1);
      pulseLoadReq("reload after gappy");

      // Reset in the middle of a three-word image
      base = wrAddr.size();
      sendWord(32'h0000_0003);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      @(negedge clk);
      rst = 0;
      #1;
      checkOutput("midreset rx_ready", {31'd0, rxReady}, 32'd0);
      checkOutput("midreset pc_stall", {31'd0, pcStall}, 32'd1);
      checkOutput("midreset words",    {21'd0, wordsLoaded}, 32'd0);
      @(negedge clk);
      rst = 1;
      sendWord(32'h0000_0001);
      sendWord(32'hA5C3_5A3C);
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendWord(32'hA5C3_5A3C);
`endif
      waitFlag(0, "post-reset done timeout");
      checkOutput("post-reset writes", wrAddr.size() - base, 32'd1);
      if (wrAddr.size() >= base + 1) begin
         checkOutput("post-reset addr", wrAddr[base], 32'h0);
         checkOutput("post-reset dat",  wrDat[base],  32'hA5C3_5A3C);
      end
      pulseLoadReq("reload after reset");

      // Error then recovery
      sendWord(32'h0000_0000);
      waitFlag(1, "recovery error timeout");
      checkOutput("recovery error set", {31'd0, error}, 32'd1);
      pulseLoadReq("recover from error");
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendWord(32'h0000_0001);
      sendWord(32'h1234_5678);
      sendWord(32'h1234_5679);
      waitFlag(1, "bad csum timeout");
      checkOutput("bad csum error",    {31'd0, error},   32'd1);
      checkOutput("bad csum pc_stall", {31'd0, pcStall}, 32'd1);
      checkOutput("bad csum done",     {31'd0, done},    32'd0);
      pulseLoadReq("recover bad csum");
      sendWord(32'h0000_0001);
      sendWord(32'h1234_5678);
      sendWord(32'h1234_5678);
      waitFlag(0, "good csum timeout");
      checkOutput("good csum done",  {31'd0, done},  32'd1);
      checkOutput("good csum error", {31'd0, error}, 32'd0);
`else
      base = wrAddr.size();
      sendWord(32'h0000_0001);
      sendWord(32'h1234_5678);
      waitFlag(0, "recovered load timeout");
      checkOutput("recovered done", {31'd0, done}, 32'd1);
      checkOutput("recovered writes", wrAddr.size() - base, 32'd1);
      if (wrAddr.size() >= base + 1) checkOutput("recovered dat", wrDat[base], 32'h1234_5678);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
